// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the round-robin cache-line memory arbiter.
// Optional feature macro: MEM_ARB_CWF_EN (critical-word-first fills), used in mem_line_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    function automatic int idx_width(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int port_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/mem_line_arbiter_rr.sv
// Combinational round-robin picker: first requester after the last-granted port wins.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = port_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    last_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PORT_W-1:0]    idx_o,
    output logic                 any_o
);

    logic [PORT_W-1:0] p;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        p     = '0;
        // Scan starts one past the last winner so that port has lowest priority.
        for (int i = 1; i <= NUM_PORTS; i++) begin
            p = PORT_W'((int'(last_i) + i) % NUM_PORTS);
            if (!any_o && req_i[p]) begin
                any_o    = 1'b1;
                gnt_o[p] = 1'b1;
                idx_o    = p;
            end
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// N-port round-robin scheduler running one full-line burst per grant against word-wide main memory.
// Define MEM_ARB_CWF_EN to start fills at the requested word (critical-word-first).
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_SIZE      = 32,
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                                MEM_CLK,
    input  logic                                RST_N,
    input  logic [NUM_PORTS-1:0]                REQ,
    input  logic [NUM_PORTS-1:0]                REQ_WE,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0]      REQ_ADDR,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]      WR_DATA,
    output logic [NUM_PORTS-1:0]                GNT,
    output logic [$clog2(WORDS_PER_LINE)-1:0]   BEAT_IDX,
    output logic                                XFER_VALID,
    output logic [WORD_SIZE-1:0]                XFER_DATA,
    output logic                                DONE,
    output logic                                MM_RE,
    output logic                                MM_WE,
    output logic [ADDR_SIZE-3:0]                MM_ADDR,
    output logic [WORD_SIZE-1:0]                MM_DIN,
    input  logic [WORD_SIZE-1:0]                MM_DOUT,
    input  logic                                MM_VALID
);

    localparam int IDX_W  = idx_width(WORDS_PER_LINE);
    localparam int PORT_W = port_width(NUM_PORTS);
    localparam int LINE_W = ADDR_SIZE - 2 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WORDS_PER_LINE - 1);

    arb_state_e           state_q;
    logic [NUM_PORTS-1:0] gnt_q;
    logic [PORT_W-1:0]    port_q;
    logic [PORT_W-1:0]    last_q;
    logic                 we_q;
    logic                 re_q;
    logic                 wr_q;
    logic                 done_q;
    logic [LINE_W-1:0]    line_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     cnt_q;

    logic [NUM_PORTS-1:0] arb_gnt;
    logic [PORT_W-1:0]    arb_idx;
    logic                 arb_any;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr (
        .req_i  (REQ),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [IDX_W-1:0]     start_idx;
    logic [WORD_SIZE-1:0] wr_word;
    logic                 xfer;
    logic                 unused_addr_bits;

    assign sel_we   = REQ_WE[arb_idx];
    assign sel_addr = REQ_ADDR[arb_idx*ADDR_SIZE +: ADDR_SIZE];
    assign wr_word  = WR_DATA[port_q*WORD_SIZE +: WORD_SIZE];

`ifdef MEM_ARB_CWF_EN
    assign start_idx = sel_we ? '0 : sel_addr[IDX_W+1:2];
`else
    assign start_idx = '0;
`endif
    // Byte offset and (without CWF) word offset never reach main memory.
    assign unused_addr_bits = ^sel_addr[IDX_W+1:0];

    always_ff @(posedge MEM_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            port_q  <= '0;
            last_q  <= PORT_W'(NUM_PORTS - 1);
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q   <= arb_gnt;
                        port_q  <= arb_idx;
                        we_q    <= sel_we;
                        line_q  <= sel_addr[ADDR_SIZE-1:IDX_W+2];
                        idx_q   <= start_idx;
                        cnt_q   <= '0;
                        re_q    <= ~sel_we;
                        wr_q    <= sel_we;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (MM_VALID) begin
                        re_q <= 1'b0;
                        wr_q <= 1'b0;
                        if (cnt_q == LAST_BEAT) begin
                            done_q  <= 1'b1;
                            gnt_q   <= '0;
                            last_q  <= port_q;
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q   <= cnt_q + 1'b1;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // One strobe-low cycle lets main memory restart its latency count.
                    re_q    <= ~we_q;
                    wr_q    <= we_q;
                    state_q <= ST_ISSUE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign xfer       = (state_q == ST_ISSUE) && MM_VALID;
    assign XFER_VALID = xfer;
    assign XFER_DATA  = (xfer && !we_q) ? MM_DOUT : '0;
    assign GNT        = gnt_q;
    assign BEAT_IDX   = idx_q;
    assign DONE       = done_q;
    assign MM_RE      = re_q;
    assign MM_WE      = wr_q;
    assign MM_ADDR    = {line_q, idx_q};
    assign MM_DIN     = wr_q ? wr_word : '0;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter with a variable-latency main-memory model.
module tb_mem_line_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] wr_data;
    logic [1:0]  gnt;
    logic [2:0]  beat_idx;
    logic        xfer_valid;
    logic [31:0] xfer_data;
    logic        done;
    logic        mm_re;
    logic        mm_we;
    logic [29:0] mm_addr;
    logic [31:0] mm_din;
    logic [31:0] mm_dout;
    logic        mm_valid;

    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [1:0]  gnt;
        logic        we;
        logic [29:0] addr;
        logic [2:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];

    logic [7:0] mm_d = 8'd3;
    int         mm_cnt = 0;

    mem_line_arbiter #(
        .NUM_PORTS      (2),
        .ADDR_SIZE      (32),
        .WORD_SIZE      (32),
        .WORDS_PER_LINE (8)
    ) dut (
        .MEM_CLK    (clk),
        .RST_N      (rst_n),
        .REQ        (req),
        .REQ_WE     (req_we),
        .REQ_ADDR   (req_addr),
        .WR_DATA    (wr_data),
        .GNT        (gnt),
        .BEAT_IDX   (beat_idx),
        .XFER_VALID (xfer_valid),
        .XFER_DATA  (xfer_data),
        .DONE       (done),
        .MM_RE      (mm_re),
        .MM_WE      (mm_we),
        .MM_ADDR    (mm_addr),
        .MM_DIN     (mm_din),
        .MM_DOUT    (mm_dout),
        .MM_VALID   (mm_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b10, a} ^ 32'h1234_5678;
    endfunction

    // Main memory: MM_VALID after mm_d cycles of continuous strobe.
    assign mm_valid = (mm_re | mm_we) && (mm_cnt == int'(mm_d));
    assign mm_dout  = mem_word(mm_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          mm_cnt <= 0;
        else if ((mm_re | mm_we) && !mm_valid) mm_cnt <= mm_cnt + 1;
        else                                 mm_cnt <= 0;
    end

    // Requesters supply a per-beat write word derived from the current index.
    assign wr_data = {32'hA0 + {29'd0, beat_idx}, 32'hB0 + {29'd0, beat_idx}};

    always @(negedge clk) begin
        beat_t e;
        if (rst_n === 1'b1 && done === 1'b1) done_cnt++;
        if (rst_n === 1'b1 && xfer_valid === 1'b1) begin
            xfer_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: unexpected beat addr=%h idx=%0d", mm_addr, beat_idx);
            end else begin
                e = sb.pop_front();
                total++;
                if (gnt !== e.gnt) begin
                    bad++;
                    $display("FAIL beat_gnt: got %b expected %b", gnt, e.gnt);
                end
                total++;
                if (mm_addr !== e.addr) begin
                    bad++;
                    $display("FAIL beat_addr: got %h expected %h", mm_addr, e.addr);
                end
                total++;
                if (beat_idx !== e.idx) begin
                    bad++;
                    $display("FAIL beat_idx: got %0d expected %0d", beat_idx, e.idx);
                end
                total++;
                if ({mm_re, mm_we} !== {~e.we, e.we}) begin
                    bad++;
                    $display("FAIL beat_strobe: got re=%b we=%b expected we=%b", mm_re, mm_we, e.we);
                end
                total++;
                if (e.we && mm_din !== e.data) begin
                    bad++;
                    $display("FAIL beat_wdata: got %h expected %h", mm_din, e.data);
                end else if (!e.we && xfer_data !== e.data) begin
                    bad++;
                    $display("FAIL beat_rdata: got %h expected %h", xfer_data, e.data);
                end
            end
        end
    end

    task automatic push_burst(input int port, input logic we, input logic [31:0] addr);
        beat_t e;
        logic [2:0] start;
        start = 3'd0;
`ifdef MEM_ARB_CWF_EN
        if (!we) start = addr[4:2];
`endif
        for (int k = 0; k < 8; k++) begin
            e.gnt  = (port == 1) ? 2'b10 : 2'b01;
            e.we   = we;
            e.idx  = start + 3'(k);
            e.addr = {addr[31:5], e.idx};
            e.data = we ? (((port == 1) ? 32'hA0 : 32'hB0) + {29'd0, e.idx}) : mem_word(e.addr);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int limit, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b00; req_we = 2'b00; req_addr = '0;
        repeat (2) @(negedge clk);
        total++;
        if (gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
        total++;
        if ({mm_re, mm_we} !== 2'b00) begin bad++; $display("FAIL rst_strobe: got %b expected 00", {mm_re, mm_we}); end
        total++;
        if (done !== 1'b0 || xfer_valid !== 1'b0) begin bad++; $display("FAIL rst_pulses: got done=%b xfer=%b expected 0", done, xfer_valid); end
        total++;
        if (beat_idx !== 3'd0 || mm_addr !== 30'd0) begin bad++; $display("FAIL rst_addr: got idx=%0d addr=%h expected 0", beat_idx, mm_addr); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 2'b00) begin bad++; $display("FAIL idle_gnt: got %b expected 00", gnt); end
    endtask

    task automatic test_single_fill();
        bit ok; int n;
        @(negedge clk);
        mm_d = 8'd3; xfer_cnt = 0;
        push_burst(0, 1'b0, 32'h6020);
        req_addr[31:0] = 32'h6020; req_we[0] = 1'b0; req[0] = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 2'b01) begin bad++; $display("FAIL fill_gnt: got %b expected 01", gnt); end
        total++;
        if ({mm_re, mm_we} !== 2'b10) begin bad++; $display("FAIL fill_strobe: got %b expected 10", {mm_re, mm_we}); end
        total++;
        if (mm_addr !== 30'h1808) begin bad++; $display("FAIL fill_addr0: got %h expected 1808", mm_addr); end
        wait_done(200, ok, n);
        req[0] = 1'b0;
        total++;
        if (!ok || n + 1 != 40) begin bad++; $display("FAIL fill_done_cycle: got ok=%0d cycle=%0d expected 40", ok, n + 1); end
        total++;
        if (xfer_cnt != 8) begin bad++; $display("FAIL fill_xfers: got %0d expected 8", xfer_cnt); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL fill_sb: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_writeback();
        int re_hi; int we_hi; int n; bit ok;
        @(negedge clk);
        mm_d = 8'd2;
        push_burst(1, 1'b1, 32'h8000);
        req_addr[63:32] = 32'h8000; req_we[1] = 1'b1; req[1] = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 2'b10) begin bad++; $display("FAIL wb_gnt: got %b expected 10", gnt); end
        re_hi = (mm_re === 1'b1) ? 1 : 0;
        we_hi = (mm_we === 1'b1) ? 1 : 0;
        ok = 1'b0; n = 1;
        while (n < 200 && !ok) begin
            @(negedge clk);
            n++;
            if (mm_re === 1'b1) re_hi++;
            if (mm_we === 1'b1) we_hi++;
            if (done === 1'b1) ok = 1'b1;
        end
        req[1] = 1'b0; req_we[1] = 1'b0;
        total++;
        if (!ok || n != 32) begin bad++; $display("FAIL wb_done_cycle: got ok=%0d cycle=%0d expected 32", ok, n); end
        total++;
        if (re_hi != 0) begin bad++; $display("FAIL wb_re_seen: got %0d cycles expected 0", re_hi); end
        total++;
        if (we_hi != 24) begin bad++; $display("FAIL wb_we_cycles: got %0d expected 24", we_hi); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL wb_sb: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_rotation();
        bit ok; int n;
        @(negedge clk);
        mm_d = 8'd0;
        for (int r = 0; r < 2; r++) begin
            push_burst(0, 1'b0, 32'h1000 + 32'(r) * 32'h100);
            push_burst(1, 1'b0, 32'h2040 + 32'(r) * 32'h100);
            req_addr = {32'h2040 + 32'(r) * 32'h100, 32'h1000 + 32'(r) * 32'h100};
            req_we = 2'b00; req = 2'b11;
            @(negedge clk);
            total++;
            if (gnt !== 2'b01) begin bad++; $display("FAIL rot_first_%0d: got %b expected 01", r, gnt); end
            wait_done(100, ok, n);
            req[0] = 1'b0;
            total++;
            if (!ok || n + 1 != 16) begin bad++; $display("FAIL rot_len0_%0d: got ok=%0d cycle=%0d expected 16", r, ok, n + 1); end
            @(negedge clk);
            @(negedge clk);
            total++;
            if (gnt !== 2'b10) begin bad++; $display("FAIL rot_second_%0d: got %b expected 10", r, gnt); end
            wait_done(100, ok, n);
            req[1] = 1'b0;
            total++;
            if (!ok) begin bad++; $display("FAIL rot_done1_%0d: got timeout expected DONE", r); end
            @(negedge clk);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rot_sb: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_cwf();
        bit ok; int n;
        logic [29:0] first;
        mm_d = 8'd1;
`ifdef MEM_ARB_CWF_EN
        first = 30'h180D;
`else
        first = 30'h1808;
`endif
        push_burst(0, 1'b0, 32'h6034);
        req_addr[31:0] = 32'h6034; req_we[0] = 1'b0; req[0] = 1'b1;
        @(negedge clk);
        total++;
        if (mm_addr !== first) begin bad++; $display("FAIL cwf_first_addr: got %h expected %h", mm_addr, first); end
        wait_done(200, ok, n);
        req[0] = 1'b0;
        total++;
        if (!ok || n + 1 != 24) begin bad++; $display("FAIL cwf_done_cycle: got ok=%0d cycle=%0d expected 24", ok, n + 1); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL cwf_sb: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_drop_req();
        bit ok; int n;
        @(negedge clk);
        mm_d = 8'd0; xfer_cnt = 0; done_cnt = 0;
        push_burst(1, 1'b0, 32'h4000);
        req_addr[63:32] = 32'h4000; req_we[1] = 1'b0; req[1] = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 2'b10) begin bad++; $display("FAIL drop_gnt: got %b expected 10", gnt); end
        repeat (5) @(negedge clk);
        req[1] = 1'b0;
        wait_done(100, ok, n);
        total++;
        if (!ok || n + 6 != 16) begin bad++; $display("FAIL drop_done_cycle: got ok=%0d cycle=%0d expected 16", ok, n + 6); end
        repeat (10) @(negedge clk);
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL drop_done_pulses: got %0d expected 1", done_cnt); end
        total++;
        if (xfer_cnt != 8) begin bad++; $display("FAIL drop_xfers: got %0d expected 8", xfer_cnt); end
        total++;
        if (gnt !== 2'b00) begin bad++; $display("FAIL drop_regrant: got %b expected 00", gnt); end
    endtask

    task automatic test_reset_mid();
        bit ok; bit found; int n;
        @(negedge clk);
        mm_d = 8'd3;
        push_burst(0, 1'b0, 32'h6020);
        req_addr[31:0] = 32'h6020; req_we[0] = 1'b0; req[0] = 1'b1;
        @(negedge clk);
        found = 1'b0; n = 0;
        while (n < 100 && !found) begin
            @(negedge clk);
            n++;
            if (beat_idx === 3'd3 && mm_re === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rstmid_beat3: got timeout expected beat 3 strobe"); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mm_re, mm_we} !== 2'b00) begin bad++; $display("FAIL rstmid_strobe: got %b expected 00", {mm_re, mm_we}); end
        total++;
        if (gnt !== 2'b00) begin bad++; $display("FAIL rstmid_gnt: got %b expected 00", gnt); end
        sb.delete();
        req = 2'b10; req_we = 2'b00; req_addr[63:32] = 32'h3000;
        mm_d = 8'd1;
        push_burst(1, 1'b0, 32'h3000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (gnt !== 2'b10) begin bad++; $display("FAIL rstmid_regrant: got %b expected 10", gnt); end
        total++;
        if (mm_addr !== 30'h0C00) begin bad++; $display("FAIL rstmid_addr: got %h expected 0c00", mm_addr); end
        wait_done(200, ok, n);
        req[1] = 1'b0;
        total++;
        if (!ok || sb.size() != 0) begin bad++; $display("FAIL rstmid_burst: got ok=%0d left=%0d expected done with 0 left", ok, sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_fill();
        test_writeback();
        test_rotation();
        test_cwf();
        test_drop_req();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
